// File: rtl/cvp14_mem_pkg.sv
// Shared types and constants for the cvp14 memory responder.
// The optional statistics outputs are enabled by defining CVP14_MEM_STATS_EN.
package cvp14_mem_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned ADDR_BUS_W = 16;
  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned BURST_MAX  = 16;
  localparam int unsigned BURST_W    = 5;
  localparam int unsigned RD_CNT_W   = 32;
  localparam int unsigned WR_CNT_W   = 32;
  localparam int unsigned OVF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RD_BURST = 2'b01,
    WR_BURST = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_OOR  = 2'b01,
    CAUSE_COLL = 2'b10
  } err_cause_e;

  // One processor-side request as sampled on a Clk1 edge.
  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [ADDR_BUS_W-1:0] addr;
    logic [WORD_W-1:0]     data;
  } mem_req_t;

endpackage

// File: rtl/cvp14_mem_responder_if.sv
// Processor-to-memory bus for the cvp14 memory responder.
// Statistics signals exist only when CVP14_MEM_STATS_EN is defined.
interface cvp14_mem_responder_if;
  import cvp14_mem_pkg::*;

  logic [ADDR_BUS_W-1:0] Addr;
  logic                  RD;
  logic                  WR;
  logic                  V;
  logic [WORD_W-1:0]     DataIn;
  logic [WORD_W-1:0]     DataOut;
  logic                  Err;
  logic [1:0]            ErrCause;
  logic [BURST_W-1:0]    BurstLen;
`ifdef CVP14_MEM_STATS_EN
  logic [RD_CNT_W-1:0]   RdCount;
  logic [WR_CNT_W-1:0]   WrCount;
  logic [OVF_CNT_W-1:0]  OvfCount;
`endif

  modport master (
    output Addr, RD, WR, V, DataIn,
    input  DataOut, Err, ErrCause, BurstLen
`ifdef CVP14_MEM_STATS_EN
    , input RdCount, WrCount, OvfCount
`endif
  );

  modport slave (
    input  Addr, RD, WR, V, DataIn,
    output DataOut, Err, ErrCause, BurstLen
`ifdef CVP14_MEM_STATS_EN
    , output RdCount, WrCount, OvfCount
`endif
  );

endinterface

// File: rtl/cvp14_mem_array.sv
// Single-port word storage: synchronous write, registered synchronous read.
// clr forces the read register to zero (reset and out-of-range reads).
module cvp14_mem_array
  import cvp14_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WORD_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents carry no reset so they survive a block reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/cvp14_mem_responder.sv
// Memory responder: burst-tracking FSM, sticky error capture and optional
// statistics (CVP14_MEM_STATS_EN) around a cvp14_mem_array.
module cvp14_mem_responder
  import cvp14_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                  Clk1,
  input  logic                  Reset,
  cvp14_mem_responder_if.slave  bus
);

  mem_req_t              req;
  logic                  oor_c;
  logic                  wr_en_c;
  logic                  rd_en_c;
  logic                  clr_c;
  err_cause_e            cause_now_c;

  state_e                state_q, state_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [ADDR_BUS_W-1:0] prev_q, prev_d;
  logic                  err_q, err_d;
  err_cause_e            cause_q, cause_d;

  assign req   = '{rd: bus.RD, wr: bus.WR, addr: bus.Addr, data: bus.DataIn};
  assign oor_c = (req.addr >> ADDR_W) != '0;

  // A collision performs the write and drops the read.
  assign wr_en_c = ~Reset & req.wr & ~oor_c;
  assign rd_en_c = ~Reset & req.rd & ~req.wr & ~oor_c;
  assign clr_c   = Reset | (req.rd & ~req.wr & oor_c);

  always_comb begin
    cause_now_c = CAUSE_NONE;
    if (req.rd && req.wr) begin
      cause_now_c = CAUSE_COLL;
    end else if ((req.rd || req.wr) && oor_c) begin
      cause_now_c = CAUSE_OOR;
    end
  end

  // Next-state, burst length and error capture.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    prev_d  = prev_q;
    err_d   = err_q;
    cause_d = cause_q;

    if (req.wr) begin
      state_d = WR_BURST;
    end else if (req.rd) begin
      state_d = RD_BURST;
    end else begin
      state_d = IDLE;
    end

    if (state_d == IDLE) begin
      burst_d = '0;
    end else if (state_d != state_q || req.addr != prev_q + ADDR_BUS_W'(1)) begin
      burst_d = BURST_W'(1);
    end else if (burst_q < BURST_W'(BURST_MAX)) begin
      burst_d = burst_q + BURST_W'(1);
    end

    if (req.rd || req.wr) begin
      prev_d = req.addr;
    end

    if (!err_q && cause_now_c != CAUSE_NONE) begin
      err_d   = 1'b1;
      cause_d = cause_now_c;
    end
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      prev_q  <= '0;
      err_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      prev_q  <= prev_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  cvp14_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (Clk1),
    .wr_en   (wr_en_c),
    .rd_en   (rd_en_c),
    .clr     (clr_c),
    .addr    (req.addr[ADDR_W-1:0]),
    .wr_data (req.data),
    .rd_data (bus.DataOut)
  );

  assign bus.Err      = err_q;
  assign bus.ErrCause = cause_q;
  assign bus.BurstLen = burst_q;

`ifdef CVP14_MEM_STATS_EN
  logic [RD_CNT_W-1:0]  rd_cnt_q;
  logic [WR_CNT_W-1:0]  wr_cnt_q;
  logic [OVF_CNT_W-1:0] ovf_cnt_q;

  // Saturating counters; a read counts when accepted, even out of range.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ovf_cnt_q <= '0;
    end else begin
      if (req.rd && !req.wr && rd_cnt_q != '1) begin
        rd_cnt_q <= rd_cnt_q + RD_CNT_W'(1);
      end
      if (wr_en_c && wr_cnt_q != '1) begin
        wr_cnt_q <= wr_cnt_q + WR_CNT_W'(1);
      end
      if (bus.V && ovf_cnt_q != '1) begin
        ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
      end
    end
  end

  assign bus.RdCount  = rd_cnt_q;
  assign bus.WrCount  = wr_cnt_q;
  assign bus.OvfCount = ovf_cnt_q;
`else
  logic unused_v;
  assign unused_v = bus.V;
`endif

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Directed self-checking bench for cvp14_mem_responder (ADDR_W = 12).
// Stats checks are compiled in when CVP14_MEM_STATS_EN is defined.
module tb_cvp14_mem_responder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  cvp14_mem_responder_if bus ();

  cvp14_mem_responder #(.ADDR_W(12)) dut (
    .Clk1  (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one request for one edge; outputs are sampled 1 time unit later.
  task automatic step(input logic rd, input logic wr, input logic [15:0] a,
                      input logic [15:0] d);
    bus.RD     = rd;
    bus.WR     = wr;
    bus.Addr   = a;
    bus.DataIn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    n_cmp++; if (bus.DataOut !== 16'h0000) begin n_fail++; $display("FAIL reset_dataout got %h want 0000", bus.DataOut); end
    n_cmp++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.Err); end
    n_cmp++; if (bus.ErrCause !== 2'b00) begin n_fail++; $display("FAIL reset_cause got %b want 00", bus.ErrCause); end
    n_cmp++; if (bus.BurstLen !== 5'd0) begin n_fail++; $display("FAIL reset_burst got %0d want 0", bus.BurstLen); end
`ifdef CVP14_MEM_STATS_EN
    n_cmp++; if (bus.RdCount !== 32'd0) begin n_fail++; $display("FAIL reset_rdcount got %0d want 0", bus.RdCount); end
`endif
    rst = 1'b0;
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic test_write_read();
    step(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    n_cmp++; if (bus.DataOut !== 16'h0000) begin n_fail++; $display("FAIL wr_holds_dataout got %h want 0000", bus.DataOut); end
    n_cmp++; if (bus.BurstLen !== 5'd1) begin n_fail++; $display("FAIL wr_burst got %0d want 1", bus.BurstLen); end
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    n_cmp++; if (bus.DataOut !== 16'hBEEF) begin n_fail++; $display("FAIL raw_read got %h want beef", bus.DataOut); end
    n_cmp++; if (bus.BurstLen !== 5'd1) begin n_fail++; $display("FAIL rd_after_wr_burst got %0d want 1", bus.BurstLen); end
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    n_cmp++; if (bus.DataOut !== 16'hBEEF) begin n_fail++; $display("FAIL idle_hold got %h want beef", bus.DataOut); end
    n_cmp++; if (bus.BurstLen !== 5'd0) begin n_fail++; $display("FAIL idle_burst got %0d want 0", bus.BurstLen); end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 16'h0100 + 16'(i), 16'(i));
      n_cmp++; if (bus.BurstLen !== 5'((i < 15) ? i + 1 : 16)) begin n_fail++; $display("FAIL wr_burst_len[%0d] got %0d want %0d", i, bus.BurstLen, (i < 15) ? i + 1 : 16); end
    end
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0000);
      n_cmp++; if (bus.DataOut !== 16'(i)) begin n_fail++; $display("FAIL rd_burst_data[%0d] got %h want %h", i, bus.DataOut, 16'(i)); end
      n_cmp++; if (bus.BurstLen !== 5'((i < 15) ? i + 1 : 16)) begin n_fail++; $display("FAIL rd_burst_len[%0d] got %0d want %0d", i, bus.BurstLen, (i < 15) ? i + 1 : 16); end
    end
    n_cmp++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL burst_no_err got %b want 0", bus.Err); end
  endtask

  task automatic test_collision();
    step(1'b1, 1'b1, 16'h0020, 16'h1234);
    n_cmp++; if (bus.DataOut !== 16'h0010) begin n_fail++; $display("FAIL coll_hold got %h want 0010", bus.DataOut); end
    n_cmp++; if (bus.Err !== 1'b1) begin n_fail++; $display("FAIL coll_err got %b want 1", bus.Err); end
    n_cmp++; if (bus.ErrCause !== 2'b10) begin n_fail++; $display("FAIL coll_cause got %b want 10", bus.ErrCause); end
    n_cmp++; if (bus.BurstLen !== 5'd1) begin n_fail++; $display("FAIL coll_burst got %0d want 1", bus.BurstLen); end
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    n_cmp++; if (bus.DataOut !== 16'h1234) begin n_fail++; $display("FAIL coll_written got %h want 1234", bus.DataOut); end
    step(1'b1, 1'b0, 16'h1000, 16'h0000);
    n_cmp++; if (bus.DataOut !== 16'h0000) begin n_fail++; $display("FAIL oor_after_coll_data got %h want 0000", bus.DataOut); end
    n_cmp++; if (bus.ErrCause !== 2'b10) begin n_fail++; $display("FAIL first_cause_kept got %b want 10", bus.ErrCause); end
  endtask

  task automatic test_out_of_range();
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    n_cmp++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got %b want 0", bus.Err); end
    step(1'b0, 1'b1, 16'h0000, 16'hA5A5);
    step(1'b1, 1'b0, 16'h1000, 16'h0000);
    n_cmp++; if (bus.DataOut !== 16'h0000) begin n_fail++; $display("FAIL oor_rd_data got %h want 0000", bus.DataOut); end
    n_cmp++; if (bus.Err !== 1'b1) begin n_fail++; $display("FAIL oor_err got %b want 1", bus.Err); end
    n_cmp++; if (bus.ErrCause !== 2'b01) begin n_fail++; $display("FAIL oor_cause got %b want 01", bus.ErrCause); end
    step(1'b0, 1'b1, 16'h1000, 16'hFFFF);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    n_cmp++; if (bus.DataOut !== 16'hA5A5) begin n_fail++; $display("FAIL oor_wr_dropped got %h want a5a5", bus.DataOut); end
    step(1'b1, 1'b0, 16'h0FFF, 16'h0000);
    step(1'b1, 1'b0, 16'h1000, 16'h0000);
    n_cmp++; if (bus.BurstLen !== 5'd2) begin n_fail++; $display("FAIL oor_counts_burst got %0d want 2", bus.BurstLen); end
    step(1'b1, 1'b0, 16'hFFFF, 16'h0000);
    n_cmp++; if (bus.BurstLen !== 5'd1) begin n_fail++; $display("FAIL nonseq_burst got %0d want 1", bus.BurstLen); end
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    n_cmp++; if (bus.BurstLen !== 5'd2) begin n_fail++; $display("FAIL wrap_burst got %0d want 2", bus.BurstLen); end
    n_cmp++; if (bus.DataOut !== 16'hA5A5) begin n_fail++; $display("FAIL wrap_data got %h want a5a5", bus.DataOut); end
    n_cmp++; if (bus.ErrCause !== 2'b01) begin n_fail++; $display("FAIL oor_cause_kept got %b want 01", bus.ErrCause); end
  endtask

  task automatic test_reset_mid_burst();
    step(1'b0, 1'b1, 16'h0030, 16'h1111);
    step(1'b0, 1'b1, 16'h0031, 16'h2222);
    n_cmp++; if (bus.BurstLen !== 5'd2) begin n_fail++; $display("FAIL pre_reset_burst got %0d want 2", bus.BurstLen); end
    rst = 1'b1;
    step(1'b0, 1'b1, 16'h0030, 16'hDEAD);
    n_cmp++; if (bus.BurstLen !== 5'd0) begin n_fail++; $display("FAIL mid_reset_burst got %0d want 0", bus.BurstLen); end
    n_cmp++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_err got %b want 0", bus.Err); end
    step(1'b1, 1'b1, 16'h0031, 16'hDEAD);
    n_cmp++; if (bus.DataOut !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_data got %h want 0000", bus.DataOut); end
    n_cmp++; if (bus.ErrCause !== 2'b00) begin n_fail++; $display("FAIL mid_reset_cause got %b want 00", bus.ErrCause); end
    rst = 1'b0;
    step(1'b1, 1'b0, 16'h0030, 16'h0000);
    n_cmp++; if (bus.DataOut !== 16'h1111) begin n_fail++; $display("FAIL keep_0030 got %h want 1111", bus.DataOut); end
    step(1'b1, 1'b0, 16'h0031, 16'h0000);
    n_cmp++; if (bus.DataOut !== 16'h2222) begin n_fail++; $display("FAIL keep_0031 got %h want 2222", bus.DataOut); end
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    n_cmp++; if (bus.DataOut !== 16'hBEEF) begin n_fail++; $display("FAIL keep_0010 got %h want beef", bus.DataOut); end
    n_cmp++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL post_reset_err got %b want 0", bus.Err); end
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

`ifdef CVP14_MEM_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    bus.V = 1'b1;
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    step(1'b1, 1'b0, 16'h0011, 16'h0000);
    step(1'b0, 1'b1, 16'h0040, 16'h0001);
    step(1'b0, 1'b1, 16'h0041, 16'h0002);
    bus.V = 1'b0;
    step(1'b1, 1'b0, 16'h0012, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    n_cmp++; if (bus.RdCount !== 32'd3) begin n_fail++; $display("FAIL rdcount got %0d want 3", bus.RdCount); end
    n_cmp++; if (bus.WrCount !== 32'd2) begin n_fail++; $display("FAIL wrcount got %0d want 2", bus.WrCount); end
    n_cmp++; if (bus.OvfCount !== 16'd4) begin n_fail++; $display("FAIL ovfcount got %0d want 4", bus.OvfCount); end
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    n_cmp++; if (bus.RdCount !== 32'd0) begin n_fail++; $display("FAIL rdcount_clr got %0d want 0", bus.RdCount); end
    n_cmp++; if (bus.WrCount !== 32'd0) begin n_fail++; $display("FAIL wrcount_clr got %0d want 0", bus.WrCount); end
    n_cmp++; if (bus.OvfCount !== 16'd0) begin n_fail++; $display("FAIL ovfcount_clr got %0d want 0", bus.OvfCount); end
  endtask
`endif

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.RD     = 1'b0;
    bus.WR     = 1'b0;
    bus.V      = 1'b0;
    bus.Addr   = 16'h0000;
    bus.DataIn = 16'h0000;
    test_reset();
    test_write_read();
    test_burst();
    test_collision();
    test_out_of_range();
    test_reset_mid_burst();
`ifdef CVP14_MEM_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
